// File: rtl/bp_fe_queue_enqueuer.sv
// FE-side producer of the FE->BE fetch queue: packs fetch results into queue messages in a 2-entry FIFO.
// Optional macro BP_FE_QUEUE_PERF_EN adds saturating dequeue and stall counters.
package bp_fe_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int instr_width_gp = 32;
  localparam int vaddr_width_gp = 39;
  localparam int bmeta_width_gp = 36;

  localparam int fetch_width_gp =
    vaddr_width_gp + instr_width_gp + bmeta_width_gp;
  localparam int exc_pad_width_gp =
    fetch_width_gp - vaddr_width_gp - 3;

  function automatic int bp_cfg_vaddr_width(bp_params_e cfg);
    unique case (cfg)
      e_bp_default_cfg: return vaddr_width_gp;
      default:          return vaddr_width_gp;
    endcase
  endfunction

  function automatic int bp_cfg_bmeta_width(bp_params_e cfg);
    unique case (cfg)
      e_bp_default_cfg: return bmeta_width_gp;
      default:          return bmeta_width_gp;
    endcase
  endfunction

  typedef enum logic [0:0] {
    e_fe_fetch     = 1'b0,
    e_fe_exception = 1'b1
  } bp_fe_msg_type_e;

  typedef enum logic [2:0] {
    e_instr_misaligned   = 3'd0,
    e_itlb_miss          = 3'd1,
    e_instr_page_fault   = 3'd2,
    e_instr_access_fault = 3'd3,
    e_icache_miss        = 3'd4
  } bp_fe_exception_code_e;

  typedef struct packed {
    logic [vaddr_width_gp-1:0] pc;
    logic [instr_width_gp-1:0] instr;
    logic [bmeta_width_gp-1:0] branch_metadata_fwd;
  } bp_fe_fetch_s;

  typedef struct packed {
    logic [vaddr_width_gp-1:0]   vaddr;
    bp_fe_exception_code_e       exception_code;
    logic [exc_pad_width_gp-1:0] padding;
  } bp_fe_exception_s;

  typedef union packed {
    bp_fe_fetch_s     fetch;
    bp_fe_exception_s exception;
  } bp_fe_msg_u;

  typedef struct packed {
    bp_fe_msg_type_e msg_type;
    bp_fe_msg_u      msg;
  } bp_fe_queue_s;

endpackage

module bp_fe_queue_enqueuer
  import bp_fe_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  localparam int vaddr_width_p = bp_cfg_vaddr_width(bp_params_p),
  localparam int branch_metadata_fwd_width_p =
    bp_cfg_bmeta_width(bp_params_p),
  localparam int fe_queue_width_lp = $bits(bp_fe_queue_s)
) (
  input  logic clk_i,
  input  logic reset_n_i,

  input  logic fetch_v_i,
  input  logic [vaddr_width_p-1:0] fetch_pc_i,
  input  logic [instr_width_gp-1:0] fetch_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] fetch_metadata_i,
  input  logic instr_misaligned_i,
  input  logic itlb_miss_i,
  input  logic instr_page_fault_i,
  input  logic instr_access_fault_i,
  input  logic icache_miss_i,
  output logic fetch_ready_o,

  input  logic flush_i,

  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic fe_queue_v_o,
  input  logic fe_queue_ready_i,

  output logic [31:0] enq_count_o,
  output logic [31:0] stall_count_o
);

  bp_fe_queue_s          mem_r [2];
  logic                  rptr_r, wptr_r;
  logic [1:0]            count_r;
  bp_fe_queue_s          msg;
  bp_fe_exception_code_e exc_code;
  logic                  exc_any;
  logic                  enq, deq;

  assign exc_any = instr_misaligned_i | itlb_miss_i
                 | instr_page_fault_i | instr_access_fault_i
                 | icache_miss_i;

  always_comb begin
    exc_code = e_icache_miss;
    priority case (1'b1)
      instr_misaligned_i:   exc_code = e_instr_misaligned;
      itlb_miss_i:          exc_code = e_itlb_miss;
      instr_page_fault_i:   exc_code = e_instr_page_fault;
      instr_access_fault_i: exc_code = e_instr_access_fault;
      default:              exc_code = e_icache_miss;
    endcase
  end

  always_comb begin
    msg = '0;
    if (exc_any) begin
      msg.msg_type                     = e_fe_exception;
      msg.msg.exception.vaddr          = fetch_pc_i;
      msg.msg.exception.exception_code = exc_code;
    end else begin
      msg.msg_type                      = e_fe_fetch;
      msg.msg.fetch.pc                  = fetch_pc_i;
      msg.msg.fetch.instr               = fetch_instr_i;
      msg.msg.fetch.branch_metadata_fwd = fetch_metadata_i;
    end
  end

  // Ready comes only from registered occupancy, never from the BE side.
  assign fetch_ready_o = reset_n_i & (count_r != 2'd2);
  assign fe_queue_v_o  = (count_r != 2'd0) & ~flush_i;
  assign fe_queue_o    = reset_n_i ? mem_r[rptr_r] : '0;

  assign enq = fetch_v_i & fetch_ready_o & ~flush_i;
  assign deq = fe_queue_v_o & fe_queue_ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_r   <= '{default: '0};
      rptr_r  <= 1'b0;
      wptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else if (flush_i) begin
      rptr_r  <= 1'b0;
      wptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq) begin
        mem_r[wptr_r] <= msg;
        wptr_r        <= ~wptr_r;
      end
      if (deq) begin
        rptr_r <= ~rptr_r;
      end
      unique case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef BP_FE_QUEUE_PERF_EN
  logic [31:0] enq_cnt_r, stall_cnt_r;
  logic        stall;

  assign stall = fetch_v_i & ~fetch_ready_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      enq_cnt_r   <= '0;
      stall_cnt_r <= '0;
    end else begin
      if (deq && enq_cnt_r != '1) begin
        enq_cnt_r <= enq_cnt_r + 32'd1;
      end
      if (stall && stall_cnt_r != '1) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign enq_count_o   = enq_cnt_r;
  assign stall_count_o = stall_cnt_r;
`else
  assign enq_count_o   = '0;
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_bp_fe_queue_enqueuer.sv
// Directed bench for bp_fe_queue_enqueuer.
// Fetch, backpressure, exception priority, streaming, flush and reset.
module tb_bp_fe_queue_enqueuer;
  import bp_fe_pkg::*;

`ifdef BP_FE_QUEUE_PERF_EN
  localparam bit perf = 1'b1;
`else
  localparam bit perf = 1'b0;
`endif

  logic clk, rst_n;
  logic fetch_v;
  logic [vaddr_width_gp-1:0] pc;
  logic [instr_width_gp-1:0] instr;
  logic [bmeta_width_gp-1:0] meta;
  logic mis, itlb, pf, af, ic;
  logic fetch_ready, flush;
  logic [$bits(bp_fe_queue_s)-1:0] q_raw;
  logic q_v, q_ready;
  logic [31:0] enq_cnt, stall_cnt;
  bp_fe_queue_s q;

  int checks = 0;
  int failures = 0;

  assign q = bp_fe_queue_s'(q_raw);

  bp_fe_queue_enqueuer dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .fetch_v_i(fetch_v),
    .fetch_pc_i(pc),
    .fetch_instr_i(instr),
    .fetch_metadata_i(meta),
    .instr_misaligned_i(mis),
    .itlb_miss_i(itlb),
    .instr_page_fault_i(pf),
    .instr_access_fault_i(af),
    .icache_miss_i(ic),
    .fetch_ready_o(fetch_ready),
    .flush_i(flush),
    .fe_queue_o(q_raw),
    .fe_queue_v_o(q_v),
    .fe_queue_ready_i(q_ready),
    .enq_count_o(enq_cnt),
    .stall_count_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic v, logic [38:0] a,
                     logic [31:0] ins, logic [4:0] f);
    fetch_v = v;
    pc      = a;
    instr   = ins;
    meta    = 36'h5_a5a5_a5a5;
    {mis, itlb, pf, af, ic} = f;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  logic [4:0] exc_f [4];
  logic [2:0] exc_c [4];

  initial begin
    exc_f[0] = 5'b01101; exc_c[0] = 3'd1;
    exc_f[1] = 5'b10001; exc_c[1] = 3'd0;
    exc_f[2] = 5'b00011; exc_c[2] = 3'd3;
    exc_f[3] = 5'b00001; exc_c[3] = 3'd4;

    rst_n = 1'b1; flush = 1'b0; q_ready = 1'b0;
    drv(1'b0, '0, '0, '0);
    #1 rst_n = 1'b0;
    #2;
    check("rst_v", q_v, 0);
    check("rst_ready", fetch_ready, 0);
    check("rst_q", q_raw, 0);
    check("rst_enq", enq_cnt, 0);
    check("rst_stall", stall_cnt, 0);
    #10 rst_n = 1'b1;
    #1;
    check("post_rst_ready", fetch_ready, 1);
    check("post_rst_v", q_v, 0);
    tick();

    // single message
    q_ready = 1'b1;
    drv(1'b1, 39'h80000000, 32'h13, '0);
    tick();
    drv(1'b0, '0, '0, '0);
    #2;
    check("t1_v", q_v, 1);
    check("t1_type", q.msg_type, 0);
    check("t1_pc", q.msg.fetch.pc, 39'h80000000);
    check("t1_instr", q.msg.fetch.instr, 32'h13);
    check("t1_meta", q.msg.fetch.branch_metadata_fwd, 36'h5_a5a5_a5a5);
    tick();
    #2 check("t1_empty", q_v, 0);

    // fill and backpressure
    q_ready = 1'b0;
    drv(1'b1, 39'h100, 32'h1, '0);
    tick();
    drv(1'b1, 39'h104, 32'h2, '0);
    tick();
    drv(1'b1, 39'h108, 32'h3, '0);
    #2;
    check("full_ready", fetch_ready, 0);
    check("full_head", q.msg.fetch.pc, 39'h100);
    tick();
    drv(1'b0, '0, '0, '0);
    q_ready = 1'b1;
    #2;
    check("stall_cnt", stall_cnt, perf ? 1 : 0);
    check("deq0_v", q_v, 1);
    check("deq0_pc", q.msg.fetch.pc, 39'h100);
    tick();
    #2 check("deq1_pc", q.msg.fetch.pc, 39'h104);
    check("deq1_v", q_v, 1);
    tick();
    #2 check("no_108", q_v, 0);

    // exception priority
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 39'h2000 + 39'(i * 4), 32'hdead, exc_f[i]);
      tick();
      drv(1'b0, '0, '0, '0);
      #2;
      check("exc_type", q.msg_type, 1);
      check("exc_vaddr", q.msg.exception.vaddr, 39'h2000 + 39'(i * 4));
      check("exc_code", q.msg.exception.exception_code, exc_c[i]);
      tick();
    end
    drv(1'b1, 39'h2100, 32'h77, 5'b11111);
    fetch_v = 1'b0;
    tick();
    #2 check("exc_ignored", q_v, 0);

    // streaming, one per cycle
    do_reset();
    q_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 39'h1000 + 39'(i * 4), 32'(i), '0);
      #2;
      check("st_ready", fetch_ready, 1);
      if (i > 0) begin
        check("st_v", q_v, 1);
        check("st_pc", q.msg.fetch.pc, 39'h1000 + 39'((i - 1) * 4));
      end
      tick();
    end
    drv(1'b0, '0, '0, '0);
    #2;
    check("st_last", q.msg.fetch.pc, 39'h101c);
    tick();
    #2;
    check("st_empty", q_v, 0);
    check("st_enq", enq_cnt, perf ? 8 : 0);
    check("st_stall", stall_cnt, 0);

    // flush
    q_ready = 1'b0;
    drv(1'b1, 39'h200, 32'h1, '0);
    tick();
    drv(1'b1, 39'h204, 32'h2, '0);
    tick();
    drv(1'b1, 39'h300, 32'h3, '0);
    flush = 1'b1;
    q_ready = 1'b1;
    #2 check("fl_v0", q_v, 0);
    tick();
    flush = 1'b0;
    drv(1'b0, '0, '0, '0);
    #2;
    check("fl_v1", q_v, 0);
    check("fl_ready", fetch_ready, 1);
    drv(1'b1, 39'h400, 32'h4, '0);
    tick();
    drv(1'b0, '0, '0, '0);
    #2;
    check("fl_post_v", q_v, 1);
    check("fl_post_pc", q.msg.fetch.pc, 39'h400);
    tick();
    #2 check("fl_no_300", q_v, 0);

    // reset mid-operation
    q_ready = 1'b0;
    drv(1'b1, 39'h500, 32'h5, '0);
    tick();
    drv(1'b0, '0, '0, '0);
    #2 check("mr_v_pre", q_v, 1);
    rst_n = 1'b0;
    #1;
    check("mr_v", q_v, 0);
    check("mr_ready", fetch_ready, 0);
    check("mr_q", q_raw, 0);
    #1 rst_n = 1'b1;
    q_ready = 1'b1;
    tick();
    #2;
    check("mr_empty", q_v, 0);
    check("mr_ready1", fetch_ready, 1);
    check("mr_enq", enq_cnt, 0);
    check("mr_stall", stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_fe_queue_enqueuer.md
# bp_fe_queue_enqueuer

Producer end of the FE→BE fetch queue. It takes per-cycle fetch results from the FE pipeline, packs each one into a `bp_fe_queue_s` message, and buffers it in a 2-entry FIFO. Each message is either a fetch message (pc, instr, branch metadata) or an exception message (vaddr, priority-encoded exception code). It drives the ready&valid FE-queue interface consumed by the BE issue queue, and flushes all buffered messages on FE redirect.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: processor configuration; supplies `vaddr_width_p`, `branch_metadata_fwd_width_p`.
- `clk_i`, in, 1: the single clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `fetch_v_i`, in, 1: fetch result valid this cycle.
- `fetch_pc_i`, in, `vaddr_width_p`: fetch PC; also the exception vaddr.
- `fetch_instr_i`, in, `instr_width_gp` (32): fetched instruction.
- `fetch_metadata_i`, in, `branch_metadata_fwd_width_p`: branch metadata forwarded to the BE.
- `instr_misaligned_i`, in, 1: exception flag.
- `itlb_miss_i`, in, 1: exception flag.
- `instr_page_fault_i`, in, 1: exception flag.
- `instr_access_fault_i`, in, 1: exception flag.
- `icache_miss_i`, in, 1: exception flag.
- `fetch_ready_o`, out, 1: the FIFO accepts a message this cycle.
- `flush_i`, in, 1: redirect; discard all buffered and incoming messages.
- `fe_queue_o`, out, `fe_queue_width_lp`: head message (`bp_fe_queue_s`).
- `fe_queue_v_o`, out, 1: head message valid.
- `fe_queue_ready_i`, in, 1: the BE accepts the head message.
- `enq_count_o`, out, 32: count of messages dequeued by the BE.
- `stall_count_o`, out, 32: count of cycles in which fetch was backpressured.

## Operation
- Storage is a 2-entry circular FIFO with read pointer, write pointer (1 bit each) and a 2-bit occupancy count.
- **Enqueue** occurs when `fetch_v_i & fetch_ready_o & ~flush_i`. The message written is:
  - If any exception flag is set: `msg_type=e_fe_exception`, `msg.exception.vaddr=fetch_pc_i`. The code is chosen by fixed priority: `e_instr_misaligned` > `e_itlb_miss` > `e_instr_page_fault` > `e_instr_access_fault` > `e_icache_miss`. `fetch_instr_i` and `fetch_metadata_i` are ignored.
  - Otherwise: `msg_type=e_fe_fetch`, with `pc`, `instr` and `branch_metadata_fwd` taken from the inputs.
  - Exception flags are ignored when `fetch_v_i=0`.
- **Dequeue** occurs when `fe_queue_v_o & fe_queue_ready_i`.
- `fe_queue_v_o = (count!=0) & ~flush_i`.
- `fetch_ready_o = (count!=2)`. It depends on registered state only and never on `fe_queue_ready_i` in the same cycle.
- **Simultaneous enqueue and dequeue** at count=1: count stays 1 and both pointers advance. At count=2 no enqueue can occur; a dequeue brings count to 1.
- **Flush**: in the cycle `flush_i=1`, count and both pointers go to 0 at the next edge. No enqueue or dequeue completes in that cycle. Flush takes priority over all other events.
- **Pointer wrap-around**: both pointers are 1-bit and wrap 1→0.
- Entry storage is not cleared by flush. `fe_queue_o` is don't-care while `fe_queue_v_o=0`.

## Timing
- Latency is 1 cycle: a message enqueued at edge N is visible on `fe_queue_o` with `fe_queue_v_o=1` in cycle N+1. There is no same-cycle bypass.
- Sustained throughput is one message per cycle when the BE accepts every cycle.
- While `reset_n_i=0`, asynchronously:
  - count, pointers and counters are 0;
  - `fe_queue_v_o=0`;
  - `fetch_ready_o=0` (gated with reset);
  - `fe_queue_o=0`;
  - `enq_count_o=0`, `stall_count_o=0`.
- In the first cycle after deassertion `fetch_ready_o=1`.
- Reset asserted mid-operation drops all buffered messages immediately; no partial handshake completes.
- Once `fe_queue_v_o` is asserted, the head message is stable until dequeue or flush.

## Configuration
- Macro `BP_FE_QUEUE_PERF_EN`.
- **Defined:**
  - `enq_count_o` increments on each dequeue handshake.
  - `stall_count_o` increments each cycle with `fetch_v_i & ~fetch_ready_o`.
  - Both counters are 32-bit, saturate at `32'hFFFF_FFFF`, are not cleared by flush, and reset to 0.
- **Not defined:** both ports are tied to 0 and no counter flops are instantiated. FIFO behaviour is identical in both builds.

## Test plan
- **Reset and single message:** release reset, hold `fe_queue_ready_i=1`, present `fetch_v_i=1`, pc=`0x8000_0000`, instr=`0x0000_0013` for one cycle.
  - The next cycle shows `fe_queue_v_o=1`, `e_fe_fetch`, same pc and instr.
  - The cycle after, `fe_queue_v_o=0`.
- **Fill and backpressure:** `fe_queue_ready_i=0`, enqueue pc `0x100` then `0x104`.
  - `fetch_ready_o=0` on the third cycle, and a third fetch at `0x108` is not accepted.
  - With `PERF_EN`, `stall_count_o` increments by 1.
  - Raising ready then dequeues `0x100` then `0x104` in order.
- **Exception priority:** `fetch_v_i=1` with `itlb_miss_i=1`, `icache_miss_i=1`, `instr_page_fault_i=1`, pc `0x2000` → `e_fe_exception`, vaddr `0x2000`, code `e_itlb_miss`.
- **Simultaneous enqueue and dequeue at count=1:** stream 8 messages at `fe_queue_ready_i=1` → 8 in-order dequeues, with `fetch_ready_o` never low and, with `PERF_EN`, `enq_count_o=8`.
- **Flush:** with 2 buffered entries, assert `flush_i` with `fetch_v_i=1` (pc `0x300`).
  - `fe_queue_v_o=0` in the flush cycle and the next cycle; `0x300` is never delivered.
  - A post-flush fetch at `0x400` appears 1 cycle later.
- **Reset mid-operation:** with 1 entry buffered, pulse `reset_n_i=0` asynchronously between edges.
  - `fe_queue_v_o` drops immediately.
  - After release the FIFO is empty and the counters read 0.
